// File: rtl/fir_filter_if.sv
// Sample stream bundle for fir_filter: input sample plus the qualified filtered output.
// Bit 0 is the MSB of both 16-bit fields.
interface fir_filter_if;
   logic signed [0:15] Data;
   logic               Data_valid;
   logic signed [0:15] DataOut;

   modport master (
      output Data,
      input  Data_valid,
      input  DataOut
   );

   modport slave (
      input  Data,
      output Data_valid,
      output DataOut
   );
endinterface

// File: rtl/fir_filter.sv
// Resource-shared direct-form FIR: one multiplier and one accumulator walk the taps,
// so each filtered sample takes TAPS+1 clocks and Data is captured once per frame.
module fir_filter #(
   parameter int                  TAPS   = 16,
   parameter logic [TAPS*16-1:0]  COEFFS = {TAPS{16'sd2048}}
) (
   input  logic        CLK,
   input  logic        RST_N,
   fir_filter_if.slave bus
);
   localparam int CW = $clog2(TAPS + 1);
   localparam int IW = $clog2(TAPS);
   localparam int AW = 32 + $clog2(TAPS);
   localparam logic signed [AW-1:0] SAT_MAX = AW'(32'sd32767);
   localparam logic signed [AW-1:0] SAT_MIN = AW'(-32'sd32768);

   logic        [CW-1:0] cnt_r;
   logic signed [15:0]   x_r [TAPS];
   logic signed [AW-1:0] acc_r;
   logic signed [15:0]   out_r;
   logic                 valid_r;
   logic                 first_r;

   logic        [IW-1:0] idx_s;
   logic signed [15:0]   coef_s;
   logic signed [31:0]   prod_s;
   logic signed [AW-1:0] prod_ext_s;
   logic signed [AW-1:0] acc_base_s;

   // Arithmetic shift by 15 (floor) followed by clamping to the 16-bit signed range.
   function automatic logic signed [15:0] sat16(input logic signed [AW-1:0] v);
      logic signed [AW-1:0] s;
      s = v >>> 15;
      if (s > SAT_MAX) begin
         sat16 = 16'sh7FFF;
      end else if (s < SAT_MIN) begin
         sat16 = 16'sh8000;
      end else begin
         sat16 = s[15:0];
      end
   endfunction

   // Tap selection, shared multiply and accumulator restart on the first tap of a frame.
   always_comb begin
      idx_s      = {IW{1'b0}};
      if (cnt_r == {CW{1'b0}}) begin
         idx_s = {IW{1'b0}};
      end else begin
         idx_s = IW'(cnt_r - CW'(1));
      end
      coef_s     = $signed(COEFFS[idx_s*16 +: 16]);
      prod_s     = x_r[idx_s] * coef_s;
      prod_ext_s = {{(AW-32){prod_s[31]}}, prod_s};
      if (cnt_r == CW'(1)) begin
         acc_base_s = {AW{1'b0}};
      end else begin
         acc_base_s = acc_r;
      end
   end

   // Frame counter, delay line, accumulator and registered result/strobe.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_r   <= {CW{1'b0}};
         acc_r   <= {AW{1'b0}};
         out_r   <= 16'sd0;
         valid_r <= 1'b0;
         first_r <= 1'b1;
         for (int k = 0; k < TAPS; k++) begin
            x_r[k] <= 16'sd0;
         end
      end else begin
         if (cnt_r == CW'(TAPS)) begin
            cnt_r <= {CW{1'b0}};
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
         if (cnt_r == {CW{1'b0}}) begin
            for (int k = TAPS - 1; k > 0; k--) begin
               x_r[k] <= x_r[k-1];
            end
            x_r[0] <= bus.Data;
            // The frame right after reset has no finished accumulation to publish.
            if (!first_r) begin
               out_r   <= sat16(acc_r);
               valid_r <= 1'b1;
            end else begin
               valid_r <= 1'b0;
            end
            first_r <= 1'b0;
         end else begin
            acc_r   <= acc_base_s + prod_ext_s;
            valid_r <= 1'b0;
         end
      end
   end

   assign bus.DataOut    = out_r;
   assign bus.Data_valid = valid_r;
endmodule

// File: tb/tb_fir_filter.sv
// Scoreboard bench for fir_filter: unity-gain and gain-2 instances share one sample stream;
// a direct-form model predicts each frame's result, which is compared when the strobe fires.
module tb_fir_filter;
   localparam int TAPS = 16;
   localparam int C1   = 2048;
   localparam int C2   = 4096;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   fir_filter_if bus1 ();
   fir_filter_if bus2 ();

   fir_filter #(.TAPS(TAPS), .COEFFS({TAPS{16'sd2048}})) dut1 (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus1.slave)
   );

   fir_filter #(.TAPS(TAPS), .COEFFS({TAPS{16'sd4096}})) dut2 (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus2.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state
   int                 mcnt;
   logic               mfirst;
   logic signed [15:0] mx [TAPS];
   logic signed [15:0] q1 [$];
   logic signed [15:0] q2 [$];
   logic signed [15:0] mout1;
   logic signed [15:0] mout2;
   logic signed [15:0] held;

   task automatic check_val(input string tag, input int obs, input int exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
      end
   endtask

   function automatic logic signed [15:0] model_y(input int coef);
      longint sum;
      longint s;
      sum = 0;
      for (int k = 0; k < TAPS; k++) begin
         sum += longint'(mx[k]) * longint'(coef);
      end
      s = sum >>> 15;
      if (s > 32767) begin
         return 16'sh7FFF;
      end else if (s < -32768) begin
         return 16'sh8000;
      end else begin
         return 16'(s);
      end
   endfunction

   task automatic model_reset();
      mcnt   = 0;
      mfirst = 1'b1;
      for (int k = 0; k < TAPS; k++) mx[k] = 16'sd0;
      q1.delete();
      q2.delete();
      mout1 = 16'sd0;
      mout2 = 16'sd0;
   endtask

   // One clock: drive Data, advance the model at the edge, then compare both DUTs.
   task automatic tick(input logic signed [15:0] d);
      logic expv;
      bus1.Data = d;
      bus2.Data = d;
      @(posedge clk);
      expv = 1'b0;
      if (mcnt == 0) begin
         if (!mfirst) begin
            expv  = 1'b1;
            mout1 = q1.pop_front();
            mout2 = q2.pop_front();
         end
         mfirst = 1'b0;
         for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
         mx[0] = d;
         q1.push_back(model_y(C1));
         q2.push_back(model_y(C2));
      end
      mcnt = (mcnt == TAPS) ? 0 : mcnt + 1;
      #1;
      check_val("valid1", int'(bus1.Data_valid), int'(expv));
      check_val("valid2", int'(bus2.Data_valid), int'(expv));
      check_val("out1", int'(bus1.DataOut), int'(mout1));
      check_val("out2", int'(bus2.DataOut), int'(mout2));
   endtask

   task automatic run_const(input logic signed [15:0] d, input int n);
      for (int i = 0; i < n; i++) tick(d);
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      bus1.Data = 16'sd0;
      bus2.Data = 16'sd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_valid", int'(bus1.Data_valid), 0);
      check_val("rst_out", int'(bus1.DataOut), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Zeros: strobe every frame, output stays 0
      run_const(16'sd0, 3 * (TAPS + 1));

      // Constant 16000: ramp 1000, 2000, ... then settle
      run_const(16'sd16000, 20 * (TAPS + 1));
      check_val("settle16000", int'(bus1.DataOut), 16000);

      // Impulse: exactly one capture of 32767 inside a 17-clock window
      run_const(16'sd0, 17 * (TAPS + 1));
      run_const(16'sd32767, TAPS + 1);
      run_const(16'sd0, 18 * (TAPS + 1));

      // Full-scale negative and positive, saturating on the gain-2 instance
      run_const(-16'sd32768, 18 * (TAPS + 1));
      check_val("sat_neg", int'(bus2.DataOut), -32768);
      run_const(16'sd32767, 18 * (TAPS + 1));
      check_val("sat_pos", int'(bus2.DataOut), 32767);

      // Data toggling on non-capture clocks must not matter
      for (int f = 0; f < 20 * (TAPS + 1); f++) begin
         if (mcnt == 0) held = 16'($urandom_range(0, 65535));
         tick((mcnt == 0) ? held : 16'($urandom_range(0, 65535)));
      end

      // Reset asserted mid-frame, when the next edge would be cnt==7
      while (mcnt != 7) tick(16'sd12345);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_valid1", int'(bus1.Data_valid), 0);
      check_val("mid_rst_out1", int'(bus1.DataOut), 0);
      check_val("mid_rst_out2", int'(bus2.DataOut), 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      run_const(16'sd16000, 4 * (TAPS + 1));
      check_val("restart_ramp", int'(bus1.DataOut), 3000);
      check_val("pending1", q1.size(), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
